instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 118 +++++++++++
 tb/tb_instruction_fetch.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch/issue FSM with PC select, retire counter and misalign trap
// Misaligned jr targets trap into a terminal ERROR state until reset.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] branch_offset,
  input  logic [31:0] jr_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] inst,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        inst_valid,
  output logic [15:0] retired,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_ERROR = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [15:0] retired_q, retired_d;
  logic        err_q, err_d;

  logic [31:0] seq_pc;
  logic [31:0] branch_bytes;
  logic [31:0] next_pc;
  logic        jr_misaligned;

  assign seq_pc        = pc_q + 32'd4;
  assign branch_bytes  = branch_offset << 2;
  assign jr_misaligned = (pcsrc == 2'b10) && (jr_target[1:0] != 2'b00);

  always_comb begin
    next_pc = seq_pc;
    case (pcsrc)
      2'b00:   next_pc = seq_pc;
      2'b01:   next_pc = seq_pc + branch_bytes;
      2'b10:   next_pc = jr_target;
      default: next_pc = {seq_pc[31:28], inst_q[25:0], 2'b00};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      inst_q    <= 32'd0;
      retired_q <= 16'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    retired_d = retired_q;
    err_d     = err_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A misaligned jr traps without retiring or moving the PC.
        if (!stall) begin
          if (jr_misaligned) begin
            err_d   = 1'b1;
            state_d = S_ERROR;
          end else begin
            pc_d      = next_pc;
            retired_d = retired_q + 16'd1;
            state_d   = S_FETCH;
          end
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req   = (state_q == S_FETCH) && !rst;
    inst_valid = (state_q == S_ISSUE);
  end

  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign pc_plus4     = seq_pc;
  assign inst         = inst_q;
  assign op           = inst_q[31:26];
  assign func         = inst_q[5:0];
  assign retired      = retired_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pcsrc;
  logic [31:0] branch_offset;
  logic [31:0] jr_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] inst;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic [15:0] retired;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .pcsrc(pcsrc), .branch_offset(branch_offset),
    .jr_target(jr_target), .stall(stall), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .inst(inst), .op(op), .func(func), .pc(pc), .pc_plus4(pc_plus4),
    .inst_valid(inst_valid), .retired(retired), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts in FETCH at a negedge; acks at once, then issues with the given select.
  task automatic run_inst(input logic [31:0] data, input logic [1:0] src,
                          input logic [31:0] off, input logic [31:0] jr);
    imem_ack = 1'b1; imem_rdata = data; step();
    imem_ack = 1'b0; pcsrc = src; branch_offset = off; jr_target = jr; stall = 1'b0;
    step();
    pcsrc = 2'b00;
  endtask

  initial begin
    rst = 1'b1; pcsrc = 2'b00; branch_offset = 32'd0; jr_target = 32'd0;
    stall = 1'b0; imem_rdata = 32'd0; imem_ack = 1'b0;
    @(negedge clk); step();
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_inst", inst, 0);
    chk("rst_retired", retired, 0);
    chk("rst_err", misalign_err, 0);

    rst = 1'b0; step();
    chk("post_rst_req", imem_req, 1);
    chk("post_rst_addr", imem_addr, 32'h0);

    // sequential fetch with immediate ack
    for (int i = 0; i < 3; i++) begin
      chk("seq_addr", imem_addr, 32'(i * 4));
      chk("seq_valid_lo", inst_valid, 0);
      imem_ack = 1'b1; imem_rdata = 32'h2002_0005; step();
      imem_ack = 1'b0;
      chk("seq_valid_hi", inst_valid, 1);
      chk("seq_req_lo", imem_req, 0);
      chk("seq_inst", inst, 32'h2002_0005);
      step();
    end
    chk("seq_op", op, 6'h08);
    chk("seq_func", func, 6'h05);
    chk("seq_retired", retired, 3);
    chk("seq_addr3", imem_addr, 32'hC);

    // three wait states, then two stalled ISSUE cycles
    for (int i = 0; i < 3; i++) begin
      chk("wait_addr", imem_addr, 32'hC);
      chk("wait_req", imem_req, 1);
      step();
    end
    chk("wait_addr4", imem_addr, 32'hC);
    imem_ack = 1'b1; imem_rdata = 32'h0123_4567; step();
    stall = 1'b1; pcsrc = 2'b11; imem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      chk("stall_valid", inst_valid, 1);
      chk("stall_pc", pc, 32'hC);
      chk("stall_inst", inst, 32'h0123_4567);
      step();
    end
    stall = 1'b0; pcsrc = 2'b00; imem_ack = 1'b0;
    chk("stall_valid3", inst_valid, 1);
    chk("stall_pc3", pc, 32'hC);
    step();
    chk("unstall_addr", imem_addr, 32'h10);
    chk("unstall_retired", retired, 4);

    // branch backwards from 0x100
    run_inst(32'h0, 2'b10, 32'd0, 32'h100);
    chk("jr_100", imem_addr, 32'h100);
    run_inst(32'h0, 2'b01, 32'hFFFF_FFFE, 32'd0);
    chk("branch_back", imem_addr, 32'hFC);

    // sequential wrap at the top of the address space
    run_inst(32'h0, 2'b10, 32'd0, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    run_inst(32'h0, 2'b00, 32'd0, 32'd0);
    chk("wrap_addr", imem_addr, 32'h0);

    // j/jal keeps the upper nibble of pc+4
    run_inst(32'h0, 2'b10, 32'd0, 32'h1000_0000);
    run_inst(32'h0800_0040, 2'b11, 32'd0, 32'd0);
    chk("jump_addr", imem_addr, 32'h1000_0100);
    run_inst(32'h0, 2'b10, 32'd0, 32'h400);
    chk("jr_400", imem_addr, 32'h400);
    chk("retired_11", retired, 11);

    // misaligned jr traps
    run_inst(32'h0, 2'b10, 32'd0, 32'h402);
    chk("mis_err", misalign_err, 1);
    chk("mis_req", imem_req, 0);
    chk("mis_valid", inst_valid, 0);
    chk("mis_pc", pc, 32'h400);
    chk("mis_retired", retired, 11);
    imem_ack = 1'b1; step(); step();
    imem_ack = 1'b0;
    chk("mis_sticky", misalign_err, 1);
    chk("mis_req_hold", imem_req, 0);
    rst = 1'b1; step();
    rst = 1'b0;
    chk("mis_cleared", misalign_err, 0);
    step();
    chk("mis_refetch", imem_addr, 32'h0);

    // reset mid-fetch with a simultaneous ack
    run_inst(32'h0, 2'b10, 32'd0, 32'h200);
    chk("mid_req", imem_req, 1);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("mid_req_forced", imem_req, 0);
    step();
    rst = 1'b0; imem_ack = 1'b0;
    chk("mid_inst", inst, 0);
    chk("mid_retired", retired, 0);
    chk("mid_valid", inst_valid, 0);
    step();
    chk("mid_req_after", imem_req, 1);
    chk("mid_addr_after", imem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
